// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: shares one UART command engine among NUM_REQ requesters.
// A round-robin grant latches the requester's command, performs the cmd_vld/cmd_rdy
// handshake, waits out a short guard window and then tracks completion (cmd_rdy
// returning for writes, a read_rdy pulse for reads) or a timeout. Each transaction
// ends with a one-hot response pulse to the granted requester.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_vld         per-requester request level
//   req_cmd         flattened commands, slice i = req_cmd[i*CMD_WIDTH +: CMD_WIDTH]
//   req_ack         one-hot pulse: command accepted by the UART
//   rsp_vld         one-hot pulse: transaction finished
//   rsp_data        read data, valid with rsp_vld
//   rsp_err         timeout flag, valid with rsp_vld
//   uart_cmd        command to the UART
//   uart_cmd_vld    command valid to the UART
//   uart_cmd_rdy    UART idle / ready for a command
//   uart_read_rdy   UART read-complete pulse
//   uart_read_data  UART read data
//   busy            high whenever not idle
module uart_cmd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CMD_WIDTH  = 16,
  parameter int unsigned READ_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_vld,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]    req_cmd,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              rsp_vld,
  output logic [READ_WIDTH-1:0]           rsp_data,
  output logic                            rsp_err,
  output logic [CMD_WIDTH-1:0]            uart_cmd,
  output logic                            uart_cmd_vld,
  input  logic                            uart_cmd_rdy,
  input  logic                            uart_read_rdy,
  input  logic [READ_WIDTH-1:0]           uart_read_data,
  output logic                            busy
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StGuard  = 3'd2;
  localparam logic [2:0] StWaitWr = 3'd3;
  localparam logic [2:0] StWaitRd = 3'd4;
  localparam logic [2:0] StResp   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [IdW-1:0]        gid_q, gid_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;
  logic [TmrW-1:0]       timer_q, timer_d, timer_inc;
  logic                  guard_q, guard_d;
  logic                  expire;

  logic [IdW-1:0]        gnt_id;
  logic [IdW-1:0]        cand;
  logic                  gnt_any;

  // Round-robin search starting one past the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdW'((32'(ptr_q) + i) % NUM_REQ);
      if (!gnt_any && req_vld[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Saturating timer; expiry fires on the edge where the count reaches TIMEOUT.
  assign timer_inc = (timer_q == TmrMax) ? timer_q : timer_q + 1'b1;
  assign expire    = (timer_inc == TmrMax);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    cmd_d      = cmd_q;
    cmd_vld_d  = cmd_vld_q;
    req_ack_d  = '0;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    timer_d    = timer_q;
    guard_d    = guard_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          gid_d     = gnt_id;
          ptr_d     = gnt_id;
          cmd_d     = req_cmd[gnt_id*CMD_WIDTH +: CMD_WIDTH];
          cmd_vld_d = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (cmd_vld_q && uart_cmd_rdy) begin
          cmd_vld_d          = 1'b0;
          req_ack_d[gid_q]   = 1'b1;
          timer_d            = '0;
          guard_d            = 1'b0;
          state_d            = StGuard;
        end
      end
      StGuard: begin
        // cmd_rdy may still read high for a cycle or two after accept; ignore it here.
        timer_d = timer_inc;
        guard_d = 1'b1;
        if (guard_q) state_d = cmd_q[CMD_WIDTH-1] ? StWaitWr : StWaitRd;
        if (expire) begin
          state_d          = StResp;
          rsp_vld_d[gid_q] = 1'b1;
          rsp_data_d       = '0;
          rsp_err_d        = 1'b1;
        end
      end
      StWaitWr: begin
        timer_d = timer_inc;
        if (uart_cmd_rdy || expire) begin
          state_d          = StResp;
          rsp_vld_d[gid_q] = 1'b1;
          rsp_data_d       = '0;
          rsp_err_d        = !uart_cmd_rdy;
        end
      end
      StWaitRd: begin
        timer_d = timer_inc;
        if (uart_read_rdy || expire) begin
          state_d          = StResp;
          rsp_vld_d[gid_q] = 1'b1;
          rsp_data_d       = uart_read_rdy ? uart_read_data : '0;
          rsp_err_d        = !uart_read_rdy;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IdW'(NUM_REQ - 1);
      gid_q      <= '0;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      req_ack_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      timer_q    <= '0;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      req_ack_q  <= req_ack_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      busy_q     <= busy_d;
      timer_q    <= timer_d;
      guard_q    <= guard_d;
    end
  end

  assign req_ack      = req_ack_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign uart_cmd     = cmd_q;
  assign uart_cmd_vld = cmd_vld_q;
  assign busy         = busy_q;

endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Round-robin controller that shares one UART command engine among NUM_REQ independent requesters. It latches a granted 16-bit command and performs the cmd_vld/cmd_rdy handshake with the UART. It then tracks completion: cmd_rdy returning high for writes, the read_rdy pulse for reads. Each requester receives a one-hot response pulse carrying read data or a timeout error. The block sits between on-chip register-access masters and the UART engine.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CMD_WIDTH, 16, command width; bit CMD_WIDTH-1 = 1 write, 0 read
- READ_WIDTH, 8, read data width
- TIMEOUT, 65535, max cycles waiting for completion after issue (≥16)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_vld  in  NUM_REQ  per-requester command request, level
- req_cmd  in  NUM_REQ*CMD_WIDTH  flattened commands; slice i = req_cmd[i*CMD_WIDTH +: CMD_WIDTH]
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse: command accepted by UART
- rsp_vld  out  NUM_REQ  one-hot, 1-cycle pulse: transaction finished
- rsp_data  out  READ_WIDTH  read data, valid with rsp_vld
- rsp_err  out  1  timeout flag, valid with rsp_vld
- uart_cmd  out  CMD_WIDTH  command to UART cmd_in
- uart_cmd_vld  out  1  to UART cmd_vld
- uart_cmd_rdy  in  1  from UART cmd_rdy (high when UART idle)
- uart_read_rdy  in  1  from UART read_rdy, 1-cycle pulse
- uart_read_data  in  READ_WIDTH  from UART read_data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, GUARD, WAIT_WR, WAIT_RD, RESP.
- IDLE: if any req_vld, grant the first set bit searching from ptr+1 upward, wrapping modulo NUM_REQ. Latch the command into cmd_buf and gid; set ptr=gid; go to ISSUE. If no req_vld, stay in IDLE.
- ISSUE: uart_cmd_vld=1, uart_cmd=cmd_buf. The handshake occurs on an edge where uart_cmd_vld && uart_cmd_rdy. On that edge, pulse req_ack[gid] next cycle, clear the timer, and go to GUARD. There is no timeout in ISSUE.
- GUARD: 2 cycles, during which uart_cmd_rdy is ignored. Then go to WAIT_WR if cmd_buf[CMD_WIDTH-1]=1, else WAIT_RD.
- WAIT_WR: when uart_cmd_rdy=1, go to RESP with err=0 and data=0.
- WAIT_RD: when uart_read_rdy=1, capture uart_read_data, go to RESP with err=0.
- Timeout: the timer counts every cycle in GUARD, WAIT_WR and WAIT_RD. When it reaches TIMEOUT, go to RESP with err=1 and data=0. If completion and timeout occur in the same cycle, completion wins (err=0).
- RESP: rsp_vld[gid]=1 for one cycle with rsp_data and rsp_err. Then go to IDLE, where a new arbitration happens next cycle.
- uart_read_rdy outside WAIT_RD is ignored.
- The command is latched at grant. Dropping req_vld after grant does not cancel the command. req_cmd is sampled only in IDLE.
- The timer is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Reset mid-transaction: all state clears immediately and no response is produced. The UART frame in flight is abandoned, and the next ISSUE waits for uart_cmd_rdy.

## Timing
- Reset values: req_ack=0, rsp_vld=0, rsp_data=0, rsp_err=0, uart_cmd=0, uart_cmd_vld=0, busy=0, ptr=NUM_REQ-1 (requester 0 has first priority), state=IDLE.
- All outputs are registered.
- Grant latency: req_vld seen in IDLE at edge N gives uart_cmd_vld=1 after edge N.
- Handshake at edge M gives req_ack[gid]=1 and uart_cmd_vld=0 during cycle M..M+1.
- Completion detected at edge K gives rsp_vld during the cycle after K.
- The earliest regrant is 1 cycle after rsp_vld.
- Minimum transaction occupancy, with a UART that completes instantly, is 6 cycles from grant to IDLE.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.

## Test plan
- Single write, requester 2, cmd 16'h8A5C, UART model raises cmd_rdy 9700 cycles after accept. Expect uart_cmd=16'h8A5C, req_ack=4'b0100, then rsp_vld=4'b0100 with rsp_err=0 and rsp_data=0.
- Single read, requester 0, cmd 16'h0031, model pulses read_rdy with data 8'hC3. Expect rsp_vld=4'b0001 and rsp_data=8'hC3 one cycle after the pulse.
- All four requesters held valid for 8 transactions from reset. Expect grant order 0,1,2,3,0,1,2,3, each seeing exactly 2 req_ack pulses.
- Read with no read_rdy, TIMEOUT=100. Expect rsp_vld with rsp_err=1 and rsp_data=0 exactly TIMEOUT cycles after the handshake. A read_rdy pulse landing on the expiry cycle gives rsp_err=0.
- uart_cmd_rdy held low for 500 cycles in ISSUE. Expect uart_cmd_vld held high, no timeout, and the handshake when rdy rises.
- rst_n asserted during WAIT_RD. Expect all outputs at their reset values and no rsp_vld. After release, requester 0 is granted first.
